// File: rtl/icache_refill_if.sv
// Fetch-side and memory-controller-side handshake bundle for icache_refill.
// The slave modport is the cache's view; master is the surrounding pipeline/controller.
interface icache_refill_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
);
    logic                  if2cache_en;
    logic [ADDR_WIDTH-1:0] if2cache_PC;
    logic                  cache2if_rdy;
    logic [INST_WIDTH-1:0] cache2if_inst;
    logic                  cache_busy;
    logic                  cache2mem_upd_en;
    logic [ADDR_WIDTH-1:0] cache2mem_PC;
    logic                  mem_busy;
    logic                  mem_rdy;
    logic [INST_WIDTH-1:0] mem2cache_inst;

    modport slave (
        input  if2cache_en, if2cache_PC, mem_busy, mem_rdy, mem2cache_inst,
        output cache2if_rdy, cache2if_inst, cache_busy, cache2mem_upd_en, cache2mem_PC
    );

    modport master (
        output if2cache_en, if2cache_PC, mem_busy, mem_rdy, mem2cache_inst,
        input  cache2if_rdy, cache2if_inst, cache_busy, cache2mem_upd_en, cache2mem_PC
    );
endinterface

// File: rtl/icache_refill.sv
// Direct-mapped, one-word-per-line instruction cache with single-word refill and flush drain.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_refill #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INST_WIDTH  = 32,
    parameter int INDEX_WIDTH = 4,
    parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - 2
) (
    input  logic clk,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic clear_in,
    icache_refill_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int LINES = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_MISS   = 2'd2,
        S_DRAIN  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  req_pc_q, req_pc_d;
    logic                   if_rdy_q, if_rdy_d;
    logic [INST_WIDTH-1:0]  if_inst_q, if_inst_d;
    logic [ADDR_WIDTH-1:0]  mem_pc_q, mem_pc_d;
    logic [LINES-1:0]       valid_q;
    logic [TAG_WIDTH-1:0]   tag_q  [LINES];
    logic [INST_WIDTH-1:0]  data_q [LINES];

    logic [INDEX_WIDTH-1:0] idx_s;
    logic [TAG_WIDTH-1:0]   tag_s;
    logic                   hit_s;
    logic                   wr_en_s;
    logic                   hit_evt_s;
    logic                   miss_evt_s;
    logic                   unused_mem_busy_s;

    assign idx_s = req_pc_q[INDEX_WIDTH+1:2];
    assign tag_s = req_pc_q[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign hit_s = valid_q[idx_s] && (tag_q[idx_s] == tag_s);

    // The controller arbitrates against the LSB itself, so busy does not gate the request.
    assign unused_mem_busy_s = bus.mem_busy;

    // The refill request must drop in the mem_rdy cycle or the controller restarts the transfer.
    assign bus.cache2mem_upd_en = ((state_q == S_MISS) || (state_q == S_DRAIN)) && !bus.mem_rdy;
    assign bus.cache2mem_PC     = mem_pc_q;
    assign bus.cache2if_rdy     = if_rdy_q;
    assign bus.cache2if_inst    = if_inst_q;
    assign bus.cache_busy       = (state_q != S_IDLE);

    // Next-state, response and refill-write decode.
    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        if_rdy_d   = 1'b0;
        if_inst_d  = if_inst_q;
        mem_pc_d   = mem_pc_q;
        wr_en_s    = 1'b0;
        hit_evt_s  = 1'b0;
        miss_evt_s = 1'b0;
        if (rdy_in) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.if2cache_en && !clear_in) begin
                        req_pc_d = bus.if2cache_PC;
                        state_d  = S_LOOKUP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LOOKUP: begin
                    if (clear_in) begin
                        state_d = S_IDLE;
                    end else if (hit_s) begin
                        if_rdy_d  = 1'b1;
                        if_inst_d = data_q[idx_s];
                        hit_evt_s = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        mem_pc_d   = req_pc_q;
                        miss_evt_s = 1'b1;
                        state_d    = S_MISS;
                    end
                end
                S_MISS: begin
                    if (bus.mem_rdy) begin
                        wr_en_s = 1'b1;
                        state_d = S_IDLE;
                        if (!clear_in) begin
                            if_rdy_d  = 1'b1;
                            if_inst_d = bus.mem2cache_inst;
                        end else begin
                            if_rdy_d = 1'b0;
                        end
                    end else if (clear_in) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_MISS;
                    end
                end
                S_DRAIN: begin
                    // The flushed word is still architecturally correct, so keep it.
                    if (bus.mem_rdy) begin
                        wr_en_s = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            if_rdy_d = if_rdy_q;
        end
    end

    // Control state, request address, output registers and valid bits.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= S_IDLE;
            req_pc_q  <= {ADDR_WIDTH{1'b0}};
            if_rdy_q  <= 1'b0;
            if_inst_q <= {INST_WIDTH{1'b0}};
            mem_pc_q  <= {ADDR_WIDTH{1'b0}};
            valid_q   <= {LINES{1'b0}};
        end else begin
            state_q   <= state_d;
            req_pc_q  <= req_pc_d;
            if_rdy_q  <= if_rdy_d;
            if_inst_q <= if_inst_d;
            mem_pc_q  <= mem_pc_d;
            if (wr_en_s) begin
                valid_q[idx_s] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            tag_q[idx_s]  <= tag_s;
            data_q[idx_s] <= bus.mem2cache_inst;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Saturating hit/miss counters.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_evt_s && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
        if (miss_evt_s && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    logic unused_evt_s;
    assign unused_evt_s = hit_evt_s ^ miss_evt_s;
`endif

endmodule

// File: tb/tb_icache_refill.sv
// Directed, table-driven bench for icache_refill: fetch transactions with hand-computed
// responses, plus hand-written flush, stall and reset sequences.
module tb_icache_refill;

    logic clk;
    logic rst_in;
    logic rdy_in;
    logic clear_in;

    icache_refill_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_refill dut (
        .clk      (clk),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .clear_in (clear_in),
        .bus      (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic        flush;
        logic [31:0] data;
        logic [31:0] exp_inst;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // One fetch: hit returns after two cycles; miss refills with a 3-cycle memory wait.
    task automatic fetch(input vec_t v);
        @(negedge clk);
        bus.if2cache_en = 1'b1;
        bus.if2cache_PC = v.pc;
        @(negedge clk);
        bus.if2cache_en = 1'b0;
        chk("busy_lookup", {31'd0, bus.cache_busy}, 32'd1);
        if (v.hit) begin
            @(negedge clk);
            chk("hit_rdy", {31'd0, bus.cache2if_rdy}, 32'd1);
            chk("hit_inst", bus.cache2if_inst, v.exp_inst);
            chk("hit_no_upd", {31'd0, bus.cache2mem_upd_en}, 32'd0);
            chk("hit_idle", {31'd0, bus.cache_busy}, 32'd0);
            @(negedge clk);
            chk("hit_pulse_end", {31'd0, bus.cache2if_rdy}, 32'd0);
        end else begin
            @(negedge clk);
            chk("miss_upd", {31'd0, bus.cache2mem_upd_en}, 32'd1);
            chk("miss_pc", bus.cache2mem_PC, v.pc);
            chk("miss_no_rdy", {31'd0, bus.cache2if_rdy}, 32'd0);
            if (v.flush) begin
                clear_in = 1'b1;
                @(negedge clk);
                clear_in = 1'b0;
                chk("drain_upd", {31'd0, bus.cache2mem_upd_en}, 32'd1);
                chk("drain_busy", {31'd0, bus.cache_busy}, 32'd1);
            end
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                chk("upd_held", {31'd0, bus.cache2mem_upd_en}, 32'd1);
            end
            bus.mem_rdy        = 1'b1;
            bus.mem2cache_inst = v.data;
            #1;
            chk("upd_drop_rdy", {31'd0, bus.cache2mem_upd_en}, 32'd0);
            @(negedge clk);
            bus.mem_rdy        = 1'b0;
            bus.mem2cache_inst = 32'd0;
            chk("refill_rdy", {31'd0, bus.cache2if_rdy}, v.flush ? 32'd0 : 32'd1);
            if (!v.flush) chk("refill_inst", bus.cache2if_inst, v.exp_inst);
            chk("refill_idle", {31'd0, bus.cache_busy}, 32'd0);
            chk("refill_upd_off", {31'd0, bus.cache2mem_upd_en}, 32'd0);
            @(negedge clk);
            chk("refill_pulse_end", {31'd0, bus.cache2if_rdy}, 32'd0);
        end
    endtask

    vec_t tbl [6];
    vec_t v;

    initial begin
        tbl[0] = '{pc: 32'h10, hit: 1'b0, flush: 1'b0, data: 32'h00A0_0093, exp_inst: 32'h00A0_0093};
        tbl[1] = '{pc: 32'h10, hit: 1'b1, flush: 1'b0, data: 32'h0,         exp_inst: 32'h00A0_0093};
        tbl[2] = '{pc: 32'h50, hit: 1'b0, flush: 1'b0, data: 32'h1234_5678, exp_inst: 32'h1234_5678};
        tbl[3] = '{pc: 32'h10, hit: 1'b0, flush: 1'b0, data: 32'h00A0_0093, exp_inst: 32'h00A0_0093};
        tbl[4] = '{pc: 32'h20, hit: 1'b0, flush: 1'b1, data: 32'hDEAD_BEEF, exp_inst: 32'h0};
        tbl[5] = '{pc: 32'h20, hit: 1'b1, flush: 1'b0, data: 32'h0,         exp_inst: 32'hDEAD_BEEF};

        rst_in             = 1'b0;
        rdy_in             = 1'b1;
        clear_in           = 1'b0;
        bus.if2cache_en    = 1'b0;
        bus.if2cache_PC    = 32'd0;
        bus.mem_busy       = 1'b0;
        bus.mem_rdy        = 1'b0;
        bus.mem2cache_inst = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_rdy", {31'd0, bus.cache2if_rdy}, 32'd0);
        chk("rst_inst", bus.cache2if_inst, 32'd0);
        chk("rst_upd", {31'd0, bus.cache2mem_upd_en}, 32'd0);
        chk("rst_mpc", bus.cache2mem_PC, 32'd0);
        chk("rst_busy", {31'd0, bus.cache_busy}, 32'd0);
        rst_in = 1'b1;

        for (int i = 0; i < 4; i++) fetch(tbl[i]);
`ifdef ICACHE_STATS_EN
        chk("stats_hit", hit_cnt, 32'd1);
        chk("stats_miss", miss_cnt, 32'd3);
`endif

        // Flush during LOOKUP of a resident line: no response, no refill.
        @(negedge clk);
        bus.if2cache_en = 1'b1;
        bus.if2cache_PC = 32'h10;
        @(negedge clk);
        bus.if2cache_en = 1'b0;
        clear_in        = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
        chk("lkflush_rdy", {31'd0, bus.cache2if_rdy}, 32'd0);
        chk("lkflush_idle", {31'd0, bus.cache_busy}, 32'd0);
        chk("lkflush_upd", {31'd0, bus.cache2mem_upd_en}, 32'd0);
`ifdef ICACHE_STATS_EN
        chk("stats_hit_flush", hit_cnt, 32'd1);
        chk("stats_miss_flush", miss_cnt, 32'd3);
`endif

        for (int i = 4; i < 6; i++) fetch(tbl[i]);

        // clear_in and mem_rdy together: line written, no response.
        @(negedge clk);
        bus.if2cache_en = 1'b1;
        bus.if2cache_PC = 32'h30;
        @(negedge clk);
        bus.if2cache_en = 1'b0;
        @(negedge clk);
        chk("same_upd", {31'd0, bus.cache2mem_upd_en}, 32'd1);
        bus.mem_rdy        = 1'b1;
        bus.mem2cache_inst = 32'hCAFE_F00D;
        clear_in           = 1'b1;
        #1;
        chk("same_upd_drop", {31'd0, bus.cache2mem_upd_en}, 32'd0);
        @(negedge clk);
        bus.mem_rdy = 1'b0;
        clear_in    = 1'b0;
        chk("same_no_rdy", {31'd0, bus.cache2if_rdy}, 32'd0);
        chk("same_idle", {31'd0, bus.cache_busy}, 32'd0);
        v = '{pc: 32'h30, hit: 1'b1, flush: 1'b0, data: 32'h0, exp_inst: 32'hCAFE_F00D};
        fetch(v);

        // Stall mid-refill, then asynchronous reset mid-refill.
        @(negedge clk);
        bus.if2cache_en = 1'b1;
        bus.if2cache_PC = 32'h40;
        @(negedge clk);
        bus.if2cache_en = 1'b0;
        @(negedge clk);
        chk("stall_pre_upd", {31'd0, bus.cache2mem_upd_en}, 32'd1);
        rdy_in   = 1'b0;
        clear_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_upd", {31'd0, bus.cache2mem_upd_en}, 32'd1);
            chk("stall_mpc", bus.cache2mem_PC, 32'h40);
            chk("stall_busy", {31'd0, bus.cache_busy}, 32'd1);
            chk("stall_inst", bus.cache2if_inst, 32'hCAFE_F00D);
        end
        rdy_in   = 1'b1;
        clear_in = 1'b0;
        @(negedge clk);
        chk("post_stall_upd", {31'd0, bus.cache2mem_upd_en}, 32'd1);
        #2;
        rst_in = 1'b0;
        #1;
        chk("mrst_upd", {31'd0, bus.cache2mem_upd_en}, 32'd0);
        chk("mrst_mpc", bus.cache2mem_PC, 32'd0);
        chk("mrst_busy", {31'd0, bus.cache_busy}, 32'd0);
        chk("mrst_rdy", {31'd0, bus.cache2if_rdy}, 32'd0);
        chk("mrst_inst", bus.cache2if_inst, 32'd0);
        @(negedge clk);
        rst_in = 1'b1;
        fetch(tbl[0]);
`ifdef ICACHE_STATS_EN
        chk("stats_after_rst_miss", miss_cnt, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Direct-mapped instruction cache between instruction fetch and the memory controller.
- Serves fetch requests from its own arrays on a hit.
- On a miss, issues a single-word refill to the memory controller over the `cache2mem_upd_en` / `cache2mem_PC` / `mem_rdy` handshake. It then writes the line and returns the instruction to fetch.
- Handles pipeline flushes mid-refill without corrupting the memory controller's in-flight byte sequence.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- INST_WIDTH, 32, instruction width; one instruction per line.
- INDEX_WIDTH, 4, line index bits; 2**INDEX_WIDTH lines.
- TAG_WIDTH, ADDR_WIDTH-INDEX_WIDTH-2, stored tag bits.

Ports:
- clk  in  1  clock, rising edge.
- rst_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global enable; when low, all state holds.
- clear_in  in  1  flush from ROB (mispredict); abandons the current fetch.
- if2cache_en  in  1  fetch request valid.
- if2cache_PC  in  ADDR_WIDTH  fetch address, word-aligned.
- cache2if_rdy  out  1  one-cycle pulse: instruction valid.
- cache2if_inst  out  INST_WIDTH  returned instruction.
- cache_busy  out  1  cache not in IDLE; fetch must not issue.
- cache2mem_upd_en  out  1  refill request to memory controller.
- cache2mem_PC  out  ADDR_WIDTH  refill address.
- mem_busy  in  1  memory controller occupied (LSB or refill).
- mem_rdy  in  1  one-cycle pulse: refill word complete.
- mem2cache_inst  in  INST_WIDTH  refill word, valid only while mem_rdy=1.

Behaviour:
- Address split: index=PC[INDEX_WIDTH+1:2]; tag=PC[ADDR_WIDTH-1:INDEX_WIDTH+2]. PC[1:0] are ignored.
- Storage: valid[2**INDEX_WIDTH], tag array, data array. All valid bits are cleared by reset; tag/data arrays are not reset.
- Reset (rst_in=0, asynchronous): state=IDLE; all valid bits=0; cache2if_rdy=0, cache2if_inst=0, cache2mem_upd_en=0, cache2mem_PC=0, cache_busy=0. Reset mid-refill abandons the refill; no write occurs.
- rdy_in=0: no state, array or output register changes.
- States: IDLE, LOOKUP, MISS, DRAIN.
- IDLE:
  - if2cache_en=1 and clear_in=0 → latch PC into req_pc; go to LOOKUP.
- LOOKUP:
  - clear_in=1 → IDLE, no response.
  - Hit (valid & tag match) → cache2if_rdy=1 and cache2if_inst=data next cycle; go to IDLE. Request-to-response latency on a hit is 2 cycles.
  - Miss → MISS; cache2mem_PC=req_pc.
- MISS:
  - cache2mem_upd_en = (state==MISS) && !mem_rdy, combinational. It must drop in the mem_rdy cycle so the controller does not restart.
  - The request is held regardless of mem_busy; the controller arbitrates, with LSB taking priority.
  - mem_rdy=1 → write data=mem2cache_inst, tag, valid=1; pulse cache2if_rdy with the instruction next cycle; go to IDLE.
  - clear_in=1 with mem_rdy=0 → go to DRAIN.
  - clear_in=1 and mem_rdy=1 in the same cycle → the line is written, no response is sent, go to IDLE.
- DRAIN:
  - cache2mem_upd_en stays high until mem_rdy, because the controller cannot abort a started transfer.
  - On mem_rdy the line is still written, since the data is architecturally correct; no cache2if_rdy is sent; go to IDLE.
  - clear_in while in DRAIN is ignored.
- cache_busy=1 in every state except IDLE.
- cache2if_rdy is high for exactly one cycle per served request and never during a flush.
- Back-to-back misses to the same index: the later refill overwrites the earlier line.

Optional Feature:
- Macro ICACHE_STATS_EN.
- When defined, adds outputs hit_cnt and miss_cnt (32 bits each, reset to 0).
  - hit_cnt increments on each LOOKUP hit.
  - miss_cnt increments on each LOOKUP→MISS transition.
  - Flushed lookups are not counted.
  - Both counters saturate at 0xFFFFFFFF.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss: after reset, fetch PC=0x0000_0010; memory returns mem2cache_inst=0x00A0_0093 via mem_rdy 4 cycles later.
  - Expect cache2mem_upd_en high with cache2mem_PC=0x10 until the mem_rdy cycle.
  - Expect cache2if_rdy pulse with inst 0x00A0_0093.
- Hit: refetch PC=0x10 → cache2if_rdy two cycles after the request with 0x00A0_0093; cache2mem_upd_en stays 0.
- Conflict: fetch PC=0x50 (same index 4, different tag) → miss and refill. Then fetch PC=0x10 → miss again.
- Flush mid-refill: fetch 0x20, assert clear_in while in MISS.
  - Expect upd_en held until mem_rdy and no cache2if_rdy.
  - A subsequent fetch of 0x20 hits.
- Stall/reset: drop rdy_in for 3 cycles during MISS → outputs frozen. Then pulse rst_in low mid-refill → all outputs 0, state IDLE, and a fetch of 0x10 misses.
- With ICACHE_STATS_EN: the sequence of the first three scenarios → hit_cnt=1, miss_cnt=3.
